hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline (F, D, E, M, W).
- Combines four hazard sources into per-stage stall and flush strobes:
  - decode load-use bubbles from the operand forwarding selects,
  - execute-stage redirects,
  - multi-cycle mul/div occupancy,
  - instruction and data bus handshake waits.
- Owns the mul/div cycle counter and the wrong-path ifetch drop tracker.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_mc_counter.sv | 51 +++++
 rtl/hazard_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and default latencies for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int DEF_MUL_CYCLES = 3;
    localparam int DEF_DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_RUN,
        MC_DONE
    } mc_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stall_flush_t;

endpackage

// File: rtl/hazard_ctrl_mc_counter.sv
// hazard_ctrl_mc_counter: mul/div occupancy FSM; an N-cycle op spends 1 cycle in IDLE, N-2 in RUN, 1 in DONE.
module hazard_ctrl_mc_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      i_start,
    input  logic      i_div,
    input  logic      i_mstall,
    output mc_state_t o_state,
    output logic      o_busy,
    output logic      o_done
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

    mc_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_load;

    assign w_load  = i_div ? DIV_LOAD : MUL_LOAD;
    assign o_state = r_state;
    assign o_busy  = (r_state == MC_RUN);
    assign o_done  = (r_state == MC_DONE);

    // Whole FSM freezes under a memory stall so the result stays aligned with E.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else if (!i_mstall) begin
            case (r_state)
                MC_IDLE: if (i_start) begin
                    r_cnt   <= w_load;
                    r_state <= (w_load == '0) ? MC_DONE : MC_RUN;
                end
                MC_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= MC_DONE;
                end
                default: r_state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: merges memory, mul/div, redirect and load-use hazards into per-stage stall/flush strobes.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_use,
    input  logic ex_redirect,
    input  logic ex_mc_start,
    input  logic ex_mc_div,
    input  logic if_busy,
    input  logic i_data_ok,
    input  logic mem_req,
    input  logic d_data_ok,
    output logic stall_f,
    output logic stall_d,
    output logic stall_e,
    output logic stall_m,
    output logic flush_d,
    output logic flush_e,
    output logic flush_m,
    output logic flush_w,
    output logic drop_ifetch,
    output logic mc_busy,
    output logic mc_done
);

    mc_state_t    w_mc_state;
    stall_flush_t w_sf;
    logic         w_mstall;
    logic         w_mc_stall;
    logic         w_stall_e;
    logic         w_redirect_acc;
    logic         w_load_use;
    logic         w_drop_now;
    logic         r_drop_pending;

    hazard_ctrl_mc_counter #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_mc (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (ex_mc_start),
        .i_div   (ex_mc_div),
        .i_mstall(w_mstall),
        .o_state (w_mc_state),
        .o_busy  (mc_busy),
        .o_done  (mc_done)
    );

    assign w_mstall       = mem_req & ~d_data_ok;
    assign w_mc_stall     = (w_mc_state == MC_RUN) | ((w_mc_state == MC_IDLE) & ex_mc_start);
    assign w_stall_e      = w_mstall | w_mc_stall;
    assign w_redirect_acc = ex_redirect & ~w_stall_e & (w_mc_state != MC_RUN);
    assign w_load_use     = load_use & ~w_stall_e & ~w_redirect_acc;
    // Wrong-path response: either the one already pending or one racing the redirect itself.
    assign w_drop_now     = r_drop_pending | (w_redirect_acc & if_busy);

    // Weaker flushes are gated by stall_e, so no stage ever sees stall and flush together.
    always_comb begin
        w_sf.stall_f = w_stall_e | w_load_use | r_drop_pending | (if_busy & ~i_data_ok);
        w_sf.stall_d = w_stall_e | w_load_use;
        w_sf.stall_e = w_stall_e;
        w_sf.stall_m = w_mstall;
        w_sf.flush_d = w_redirect_acc;
        w_sf.flush_e = w_redirect_acc | w_load_use;
        w_sf.flush_m = w_mc_stall & ~w_mstall;
        w_sf.flush_w = w_mstall;
    end

    assign {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w} = resetn ? w_sf : '0;
    assign drop_ifetch = resetn & i_data_ok & w_drop_now;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_drop_pending <= 1'b0;
        else         r_drop_pending <= w_drop_now & ~i_data_ok;
    end

endmodule
